// File: rtl/governance_quorum.sv
// rtl/governance_quorum.sv - weighted k-of-n approval gate with tag-bound live/preloaded approvals
// Optional veto path enabled by defining GOV_VETO_EN.
module governance_quorum #(
   parameter int N_MAX          = 16,
   parameter int SIG_W          = $clog2(N_MAX),
   parameter int WEIGHT_W       = 4,
   parameter int SUM_W          = 8,
   parameter int TAG_W          = 32,
   parameter int TIMEOUT_CYCLES = 500_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_start,
   input  logic [TAG_W-1:0]    req_tag,
   input  logic                req_abort,
   input  logic                req_clear,
   input  logic                cfg_we,
   input  logic [SIG_W-1:0]    cfg_idx,
   input  logic [WEIGHT_W-1:0] cfg_weight,
   input  logic                cfg_k_we,
   input  logic [SUM_W-1:0]    cfg_k,
   input  logic                live_valid,
   input  logic [7:0]          live_signer,
   input  logic [TAG_W-1:0]    live_tag,
   input  logic                pre_valid,
   input  logic [7:0]          pre_signer,
   input  logic [TAG_W-1:0]    pre_tag,
   input  logic [31:0]         pre_expiry,
   input  logic [31:0]         current_timestamp,
   output logic                live_ack,
   output logic                live_reject,
   output logic                pre_ack,
   output logic                pre_reject,
   output logic [1:0]          live_code,
   output logic [1:0]          pre_code,
   output logic                approved,
   output logic                denied,
   output logic                timeout_flag,
   output logic                aborted,
   output logic                cfg_error,
   output logic                busy,
   output logic [SUM_W-1:0]    weight_sum,
   output logic [N_MAX-1:0]    approver_bitmap,
   output logic [1:0]          state
`ifdef GOV_VETO_EN
   ,
   input  logic                veto_valid,
   input  logic [7:0]          veto_signer,
   input  logic [TAG_W-1:0]    veto_tag,
   output logic                vetoed
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam int EXT_W = SUM_W + 2;
   localparam logic [SUM_W-1:0] SUM_SAT = {SUM_W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_nxt;
   logic [WEIGHT_W-1:0] weight_tab [N_MAX];
   logic [SUM_W-1:0]    threshold;
   logic [TAG_W-1:0]    tag_q;
   logic [CNT_W-1:0]    counter;

   logic                in_collect;
   logic [SIG_W-1:0]    live_idx;
   logic [SIG_W-1:0]    pre_idx;
   logic                live_in;
   logic                pre_in;
   logic [WEIGHT_W-1:0] live_w;
   logic [WEIGHT_W-1:0] pre_w;
   logic                pre_fresh;
   logic [2:0]          live_res;
   logic [2:0]          pre_res;
   logic                live_acc;
   logic                pre_acc;
   logic [N_MAX-1:0]    bitmap_mid;
   logic [N_MAX-1:0]    bitmap_nxt;
   logic [EXT_W-1:0]    sum_ext;
   logic [SUM_W-1:0]    sum_nxt;
   logic                veto_hit;
   logic                reach;
   logic                expire;

   // Returns {accept, reject_code}; checks run in the defined reject-reason order.
   function automatic logic [2:0] judge(input logic in_range, input logic [WEIGHT_W-1:0] w,
                                        input logic seen, input logic tag_ok);
      if (!in_range || w == '0) judge = {1'b0, 2'd1};
      else if (seen)            judge = {1'b0, 2'd2};
      else if (!tag_ok)         judge = {1'b0, 2'd3};
      else                      judge = {1'b1, 2'd0};
   endfunction

   always_comb begin
      in_collect = (state_q == S_COLLECT);
      live_idx   = live_signer[SIG_W-1:0];
      pre_idx    = pre_signer[SIG_W-1:0];
      live_in    = int'(live_signer) < N_MAX;
      pre_in     = int'(pre_signer) < N_MAX;
      live_w     = live_in ? weight_tab[live_idx] : '0;
      pre_w      = pre_in ? weight_tab[pre_idx] : '0;
      pre_fresh  = (pre_expiry == 32'd0) || (pre_expiry > current_timestamp);

      live_res   = judge(live_in, live_w, live_in && approver_bitmap[live_idx], live_tag == tag_q);
      live_acc   = live_valid && in_collect && live_res[2];
      bitmap_mid = approver_bitmap;
      if (live_acc) bitmap_mid[live_idx] = 1'b1;

      // Live is merged first so a same-signer preloaded approval sees it as a duplicate.
      pre_res    = judge(pre_in, pre_w, pre_in && bitmap_mid[pre_idx],
                         (pre_tag == tag_q) && pre_fresh);
      pre_acc    = pre_valid && in_collect && pre_res[2];
      bitmap_nxt = bitmap_mid;
      if (pre_acc) bitmap_nxt[pre_idx] = 1'b1;

      sum_ext = EXT_W'(weight_sum)
              + (live_acc ? EXT_W'(live_w) : EXT_W'(0))
              + (pre_acc  ? EXT_W'(pre_w)  : EXT_W'(0));
      sum_nxt = (sum_ext > EXT_W'(SUM_SAT)) ? SUM_SAT : sum_ext[SUM_W-1:0];

      reach  = (weight_sum >= threshold);
      expire = (counter == CNT_LAST);
   end

`ifdef GOV_VETO_EN
   always_comb begin
      veto_hit = 1'b0;
      if (veto_valid && in_collect && int'(veto_signer) < N_MAX)
         veto_hit = (weight_tab[veto_signer[SIG_W-1:0]] != '0) && (veto_tag == tag_q);
   end
`else
   assign veto_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_start) state_nxt = (threshold == '0) ? S_DONE : S_COLLECT;
         end
         S_COLLECT: begin
            if (req_abort || veto_hit || reach || expire) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (req_clear) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == S_COLLECT);
      state = state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_MAX; i++) weight_tab[i] <= '0;
         threshold       <= '0;
         tag_q           <= '0;
         counter         <= '0;
         weight_sum      <= '0;
         approver_bitmap <= '0;
         approved        <= 1'b0;
         denied          <= 1'b0;
         timeout_flag    <= 1'b0;
         aborted         <= 1'b0;
         cfg_error       <= 1'b0;
         live_ack        <= 1'b0;
         live_reject     <= 1'b0;
         live_code       <= 2'd0;
         pre_ack         <= 1'b0;
         pre_reject      <= 1'b0;
         pre_code        <= 2'd0;
`ifdef GOV_VETO_EN
         vetoed          <= 1'b0;
`endif
      end else begin
         // Outside COLLECT every strobe is rejected with code 0.
         live_ack    <= live_acc;
         live_reject <= live_valid && !live_acc;
         live_code   <= (live_valid && in_collect && !live_acc) ? live_res[1:0] : 2'd0;
         pre_ack     <= pre_acc;
         pre_reject  <= pre_valid && !pre_acc;
         pre_code    <= (pre_valid && in_collect && !pre_acc) ? pre_res[1:0] : 2'd0;

         if (state_q == S_IDLE) begin
            if (cfg_we && int'(cfg_idx) < N_MAX) weight_tab[cfg_idx] <= cfg_weight;
            if (cfg_k_we) threshold <= cfg_k;
         end

         case (state_q)
            S_IDLE: begin
               if (req_start) begin
                  tag_q           <= req_tag;
                  weight_sum      <= '0;
                  approver_bitmap <= '0;
                  counter         <= '0;
                  approved        <= 1'b0;
                  timeout_flag    <= 1'b0;
                  aborted         <= 1'b0;
                  denied          <= (threshold == '0);
                  cfg_error       <= (threshold == '0);
`ifdef GOV_VETO_EN
                  vetoed          <= 1'b0;
`endif
               end
            end
            S_COLLECT: begin
               // Approvals sampled on the deciding edge are still accounted.
               approver_bitmap <= bitmap_nxt;
               weight_sum      <= sum_nxt;
               counter         <= counter + 1'b1;
               if (req_abort) begin
                  denied  <= 1'b1;
                  aborted <= 1'b1;
               end else if (veto_hit) begin
                  denied  <= 1'b1;
`ifdef GOV_VETO_EN
                  vetoed  <= 1'b1;
`endif
               end else if (reach) begin
                  approved <= 1'b1;
               end else if (expire) begin
                  denied       <= 1'b1;
                  timeout_flag <= 1'b1;
               end
            end
            S_DONE: begin
               if (req_clear) begin
                  approved     <= 1'b0;
                  denied       <= 1'b0;
                  timeout_flag <= 1'b0;
                  aborted      <= 1'b0;
                  cfg_error    <= 1'b0;
`ifdef GOV_VETO_EN
                  vetoed       <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_governance_quorum.sv
// tb/tb_governance_quorum.sv - directed bench with spec-level reference model for governance_quorum
module tb_governance_quorum;

   localparam int N  = 16;
   localparam int SW = 5;
   localparam int TO = 16;
   localparam int SAT = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_start, req_abort, req_clear;
   logic [31:0]   req_tag;
   logic          cfg_we, cfg_k_we;
   logic [3:0]    cfg_idx;
   logic [3:0]    cfg_weight;
   logic [SW-1:0] cfg_k;
   logic          live_valid, pre_valid;
   logic [7:0]    live_signer, pre_signer;
   logic [31:0]   live_tag, pre_tag, pre_expiry, current_timestamp;
   logic          live_ack, live_reject, pre_ack, pre_reject;
   logic [1:0]    live_code, pre_code;
   logic          approved, denied, timeout_flag, aborted, cfg_error, busy;
   logic [SW-1:0] weight_sum;
   logic [N-1:0]  approver_bitmap;
   logic [1:0]    state;
`ifdef GOV_VETO_EN
   logic          veto_valid;
   logic [7:0]    veto_signer;
   logic [31:0]   veto_tag;
   logic          vetoed;
`endif

   int total = 0;
   int passed = 0;

   governance_quorum #(.N_MAX(N), .WEIGHT_W(4), .SUM_W(SW), .TAG_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_start(req_start), .req_tag(req_tag), .req_abort(req_abort), .req_clear(req_clear),
      .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_weight(cfg_weight), .cfg_k_we(cfg_k_we), .cfg_k(cfg_k),
      .live_valid(live_valid), .live_signer(live_signer), .live_tag(live_tag),
      .pre_valid(pre_valid), .pre_signer(pre_signer), .pre_tag(pre_tag), .pre_expiry(pre_expiry),
      .current_timestamp(current_timestamp),
      .live_ack(live_ack), .live_reject(live_reject), .pre_ack(pre_ack), .pre_reject(pre_reject),
      .live_code(live_code), .pre_code(pre_code),
      .approved(approved), .denied(denied), .timeout_flag(timeout_flag), .aborted(aborted),
      .cfg_error(cfg_error), .busy(busy), .weight_sum(weight_sum),
      .approver_bitmap(approver_bitmap), .state(state)
`ifdef GOV_VETO_EN
      , .veto_valid(veto_valid), .veto_signer(veto_signer), .veto_tag(veto_tag), .vetoed(vetoed)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Reference model: state as an int, weights as ints, sum as an unbounded int clipped to SAT.
   int          m_state, m_k, m_sum, m_cnt;
   int          m_w [N];
   logic [31:0] m_tag;
   logic [N-1:0] m_bm;
   bit          m_appr, m_den, m_to, m_ab, m_cfe, m_vet;
   bit          m_lack, m_lrej, m_pack, m_prej;
   int          m_lcode, m_pcode;

   // 4 = accept, otherwise the reject code.
   function automatic int verdict(input int sg, input logic [31:0] tg, input bit is_pre,
                                  input logic [31:0] ex, input logic [N-1:0] seen);
      if (sg >= N) return 1;
      if (m_w[sg] == 0) return 1;
      if (seen[sg]) return 2;
      if (tg != m_tag) return 3;
      if (is_pre && ex != 0 && ex <= current_timestamp) return 3;
      return 4;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int s, lc, pc;
      bit vok;
      logic [N-1:0] bm;
      if (!rst_n) begin
         m_state <= 0; m_k <= 0; m_sum <= 0; m_cnt <= 0; m_tag <= '0; m_bm <= '0;
         for (int i = 0; i < N; i++) m_w[i] <= 0;
         m_appr <= 0; m_den <= 0; m_to <= 0; m_ab <= 0; m_cfe <= 0; m_vet <= 0;
         m_lack <= 0; m_lrej <= 0; m_pack <= 0; m_prej <= 0; m_lcode <= 0; m_pcode <= 0;
      end else begin
         bm = m_bm; s = m_sum; lc = -1; pc = -1; vok = 0;
         if (live_valid) begin
            lc = (m_state == 1) ? verdict(int'(live_signer), live_tag, 0, 32'd0, bm) : 0;
            if (lc == 4) begin bm[live_signer] = 1'b1; s += m_w[live_signer]; end
         end
         if (pre_valid) begin
            pc = (m_state == 1) ? verdict(int'(pre_signer), pre_tag, 1, pre_expiry, bm) : 0;
            if (pc == 4) begin bm[pre_signer] = 1'b1; s += m_w[pre_signer]; end
         end
         if (s > SAT) s = SAT;
`ifdef GOV_VETO_EN
         vok = veto_valid && veto_signer < N && veto_tag == m_tag && m_w[veto_signer] != 0;
`endif
         m_lack <= (lc == 4); m_lrej <= (lc >= 0 && lc < 4); m_lcode <= (lc >= 0 && lc < 4) ? lc : 0;
         m_pack <= (pc == 4); m_prej <= (pc >= 0 && pc < 4); m_pcode <= (pc >= 0 && pc < 4) ? pc : 0;
         if (m_state == 0) begin
            if (cfg_we) m_w[cfg_idx] <= int'(cfg_weight);
            if (cfg_k_we) m_k <= int'(cfg_k);
            if (req_start) begin
               m_tag <= req_tag; m_bm <= '0; m_sum <= 0; m_cnt <= 0;
               m_appr <= 0; m_to <= 0; m_ab <= 0; m_vet <= 0;
               m_den <= (m_k == 0); m_cfe <= (m_k == 0);
               m_state <= (m_k == 0) ? 2 : 1;
            end
         end else if (m_state == 1) begin
            m_bm <= bm; m_sum <= s; m_cnt <= m_cnt + 1;
            if (req_abort)              begin m_state <= 2; m_den <= 1; m_ab <= 1; end
            else if (vok)               begin m_state <= 2; m_den <= 1; m_vet <= 1; end
            else if (m_sum >= m_k)      begin m_state <= 2; m_appr <= 1; end
            else if (m_cnt == TO - 1)   begin m_state <= 2; m_den <= 1; m_to <= 1; end
         end else if (req_clear) begin
            m_state <= 0; m_appr <= 0; m_den <= 0; m_to <= 0; m_ab <= 0; m_cfe <= 0; m_vet <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("state", state, m_state);
         check("busy", busy, m_state == 1);
         check("approved", approved, m_appr);
         check("denied", denied, m_den);
         check("timeout_flag", timeout_flag, m_to);
         check("aborted", aborted, m_ab);
         check("cfg_error", cfg_error, m_cfe);
         check("weight_sum", weight_sum, m_sum);
         check("approver_bitmap", approver_bitmap, m_bm);
         check("live_ack", live_ack, m_lack);
         check("live_reject", live_reject, m_lrej);
         check("live_code", live_code, m_lcode);
         check("pre_ack", pre_ack, m_pack);
         check("pre_reject", pre_reject, m_prej);
         check("pre_code", pre_code, m_pcode);
`ifdef GOV_VETO_EN
         check("vetoed", vetoed, m_vet);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      req_start = 0; req_abort = 0; req_clear = 0; cfg_we = 0; cfg_k_we = 0;
      live_valid = 0; pre_valid = 0;
`ifdef GOV_VETO_EN
      veto_valid = 0;
`endif
   endtask

   task automatic live(input int sg, input logic [31:0] tg);
      live_valid = 1; live_signer = 8'(sg); live_tag = tg;
   endtask

   task automatic pre(input int sg, input logic [31:0] tg, input logic [31:0] ex);
      pre_valid = 1; pre_signer = 8'(sg); pre_tag = tg; pre_expiry = ex;
   endtask

   task automatic cfg_w(input int idx, input int w);
      cfg_we = 1; cfg_idx = 4'(idx); cfg_weight = 4'(w); tick();
   endtask

   task automatic set_k(input int k);
      cfg_k_we = 1; cfg_k = SW'(k); tick();
   endtask

   task automatic start(input logic [31:0] tg);
      req_start = 1; req_tag = tg; tick();
   endtask

   initial begin
      int n;
      rst_n = 0;
      req_start = 0; req_abort = 0; req_clear = 0; req_tag = 0;
      cfg_we = 0; cfg_k_we = 0; cfg_idx = 0; cfg_weight = 0; cfg_k = 0;
      live_valid = 0; live_signer = 0; live_tag = 0;
      pre_valid = 0; pre_signer = 0; pre_tag = 0; pre_expiry = 0; current_timestamp = 32'd100;
`ifdef GOV_VETO_EN
      veto_valid = 0; veto_signer = 0; veto_tag = 0;
`endif
      tick(); tick();
      check("reset_state", state, 0);
      check("reset_sum", weight_sum, 0);
      check("reset_bitmap", approver_bitmap, 0);
      check("reset_busy", busy, 0);
      rst_n = 1;
      tick();

      for (int i = 0; i <= 8; i++) cfg_w(i, 1);
      cfg_w(9, 3);
      for (int i = 13; i <= 15; i++) cfg_w(i, 15);
      set_k(5);

      // Weighted approval and two-cycle decision latency
      start(32'hA1);
      check("t1_collect", state, 1);
      live(9, 32'hA1); tick(); check("t1_sum3", weight_sum, 3);
      live(2, 32'hA1); tick(); check("t1_sum4", weight_sum, 4);
      live(4, 32'hA1); tick(); check("t1_sum5", weight_sum, 5);
      check("t1_not_yet", approved, 0);
      tick();
      check("t1_approved", approved, 1);
      check("t1_bitmap", approver_bitmap, 16'h0214);
      req_clear = 1; tick();

      // Same-cycle merge
      start(32'hB2);
      live(3, 32'hB2); pre(3, 32'hB2, 0); tick();
      check("t2_live_ack", live_ack, 1);
      check("t2_pre_code", pre_code, 2);
      check("t2_sum", weight_sum, 1);
      live(5, 32'hB2); pre(6, 32'hB2, 0); tick();
      check("t2_both_sum", weight_sum, 3);
      req_abort = 1; tick();
      check("t2_aborted", aborted, 1);
      req_clear = 1; tick();

      // Rejection reasons
      start(32'hC3);
      live(1, 32'hC2); tick(); check("t3_tag_code", live_code, 3);
      live(20, 32'hC3); tick(); check("t3_range_code", live_code, 1);
      live(12, 32'hC3); tick(); check("t3_zero_w_code", live_code, 1);
      pre(2, 32'hC3, 32'd100); tick(); check("t3_expired_code", pre_code, 3);
      check("t3_sum_unchanged", weight_sum, 0);
      pre(2, 32'hC3, 32'd101); tick(); check("t3_fresh_ack", pre_ack, 1);
      live(2, 32'hC3); tick(); check("t3_dup_code", live_code, 2);
      check("t3_sum1", weight_sum, 1);
      req_abort = 1; tick();
      req_clear = 1; tick();
      live(3, 32'hC3); tick();
      check("t3_idle_reject", live_reject, 1);
      check("t3_idle_code", live_code, 0);

      // Timeout exactly TO cycles after entering COLLECT
      start(32'hD4);
      n = 0;
      live(0, 32'hD4); tick(); n++;
      live(1, 32'hD4); tick(); n++;
      while (!denied && n < 40) begin tick(); n++; end
      check("t4_timeout_cycles", n, 16);
      check("t4_timeout_flag", timeout_flag, 1);
      start(32'hD5);
      check("t4_start_ignored", state, 2);
      req_clear = 1; tick();

      // Config lock, ignored restart, threshold zero
      start(32'hE5);
      cfg_k_we = 1; cfg_k = 0; cfg_we = 1; cfg_idx = 0; cfg_weight = 15;
      req_start = 1; req_tag = 32'hE7; tick();
      tick();
      check("t5_k_locked", state, 1);
      live(9, 32'hE5); tick(); check("t5_tag_kept", live_ack, 1);
      live(1, 32'hE5); pre(2, 32'hE5, 0); tick();
      tick();
      check("t5_approved", approved, 1);
      check("t5_bitmap", approver_bitmap, 16'h0206);
      req_clear = 1; tick();
      set_k(0);
      start(32'hE8);
      check("t5_cfg_error", cfg_error, 1);
      check("t5_denied", denied, 1);
      req_clear = 1; tick();
      check("t5_idle", state, 0);
      check("t5_cleared", denied | cfg_error | approved, 0);

      // Saturation
      set_k(31);
      start(32'hF6);
      live(13, 32'hF6); pre(14, 32'hF6, 0); tick(); check("sat_30", weight_sum, 30);
      live(15, 32'hF6); tick(); check("sat_31", weight_sum, 31);
      tick(); check("sat_approved", approved, 1);
      req_clear = 1; tick();
      set_k(5);

`ifdef GOV_VETO_EN
      start(32'h77);
      for (int i = 0; i < 4; i++) begin live(i, 32'h77); tick(); end
      veto_valid = 1; veto_signer = 12; veto_tag = 32'h77; tick();
      veto_valid = 1; veto_signer = 1; veto_tag = 32'h78; tick();
      check("veto_ignored", state, 1);
      live(4, 32'h77); veto_valid = 1; veto_signer = 1; veto_tag = 32'h77; tick();
      check("veto_vetoed", vetoed, 1);
      check("veto_denied", denied, 1);
      tick();
      check("veto_not_approved", approved, 0);
      req_clear = 1; tick();
`endif

      // Asynchronous reset mid-collection
      start(32'h99);
      live(9, 32'h99); tick();
      #3 rst_n = 0;
      #1;
      check("arst_sum", weight_sum, 0);
      check("arst_state", state, 0);
      check("arst_bitmap", approver_bitmap, 0);
      @(negedge clk); #2 rst_n = 1;
      tick();
      start(32'h9A);
      check("arst_k_cleared", cfg_error, 1);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/governance_quorum.md
Name: governance_quorum

Overview:
- Weighted k-of-n approval gate for bitstream deployment; successor to the fixed-count threshold checker.
- Per-signer vote weights and the threshold are runtime-programmable. Every approval is bound to a request tag.
- Live (serial/TSSP) and FRAM-preloaded approvals are accepted in the same cycle with a defined merge order.
- Sits between the update controller (issues requests, consumes approved/denied) and the approval transports.

Parameters:
N_MAX, 16, signer slots; index width SIG_W = $clog2(N_MAX)
WEIGHT_W, 4, per-signer weight width
SUM_W, 8, accumulated weight / threshold width
TAG_W, 32, request binding tag width (hash of bitstream_id, tier, version)
TIMEOUT_CYCLES, 500_000_000, collection window in clk cycles (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_start  in  1  pulse: open collection for req_tag
req_tag  in  TAG_W  tag of the request being approved
req_abort  in  1  pulse: cancel collection
req_clear  in  1  pulse: release result, return to IDLE
cfg_we  in  1  write weight table entry
cfg_idx  in  SIG_W  signer index to write
cfg_weight  in  WEIGHT_W  weight (0 = unauthorised)
cfg_k_we  in  1  write threshold
cfg_k  in  SUM_W  threshold weight
live_valid  in  1  live approval strobe
live_signer  in  8  signer index
live_tag  in  TAG_W  tag signed by approver
pre_valid  in  1  preloaded approval strobe
pre_signer  in  8  signer index
pre_tag  in  TAG_W  tag
pre_expiry  in  32  expiry timestamp, 0 = none
current_timestamp  in  32  RTC seconds
live_ack, live_reject, pre_ack, pre_reject  out  1 each  result pulses
live_code, pre_code  out  2 each  reject reason
approved, denied, timeout_flag, aborted, cfg_error  out  1 each  result flags
busy  out  1  high in COLLECT
weight_sum  out  SUM_W  accumulated weight
approver_bitmap  out  N_MAX  accepted signers
state  out  2  IDLE=0, COLLECT=1, DONE=2

Behaviour:
- Reset: all outputs 0, state IDLE, weight table all 0, threshold register 0, timeout counter 0.
- Config: cfg_we/cfg_k_we take effect only in IDLE; ignored in COLLECT/DONE (config lock).
- IDLE, on req_start:
  - Latch req_tag; clear weight_sum, bitmap, flags and counter; go to COLLECT next edge.
  - If threshold==0, go to DONE with denied=1, cfg_error=1.
- COLLECT, each source is checked in this order; the first failure sets the reject code:
  - signer >= N_MAX or weight==0 -> code 1
  - signer already in bitmap -> code 2
  - tag != latched tag, or (pre only) expiry!=0 and expiry<=current_timestamp -> code 3
  - otherwise ack; set the bitmap bit; add weight.
- ack/reject/code are registered: they are driven the cycle after valid is sampled and last one cycle.
- Same cycle, both sources valid:
  - Live is evaluated first.
  - Same signer on both: live accepted, pre rejected with code 2.
  - Different signers: both weights are added.
  - Sum saturates at 2^SUM_W-1.
- Decision, evaluated each COLLECT cycle on the registered weight_sum:
  - req_abort -> DONE, denied=1, aborted=1.
  - else weight_sum >= threshold -> DONE, approved=1.
  - else counter == TIMEOUT_CYCLES-1 -> DONE, denied=1, timeout_flag=1.
  - Priority is abort > veto (optional feature) > approve > timeout.
- Latency: the last qualifying approval is sampled at cycle t; weight_sum updates at t+1; approved asserts at t+2.
- Approvals sampled in the transition cycle are still accounted in bitmap and weight_sum.
- Strobes outside COLLECT: reject with code 0.
- DONE:
  - Result flags, weight_sum and bitmap are held stable.
  - req_start is ignored.
  - req_clear -> IDLE; flags clear on entry to IDLE.
- req_start while in COLLECT is ignored. The tag cannot be changed mid-collection.
- Reset mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- GOV_VETO_EN defined:
  - Adds ports veto_valid(in,1), veto_signer(in,8), veto_tag(in,TAG_W) and vetoed(out,1).
  - In COLLECT, a veto whose signer has nonzero weight and whose tag matches -> DONE, denied=1, vetoed=1.
  - Veto wins over approval in the same cycle.
  - A veto that fails those checks is ignored.
- GOV_VETO_EN undefined: veto ports absent; no veto path exists.

Test Plan:
1. Weights: signers 0-8 = 1, signer 9 = 3; threshold 5. Live approvals from signers 9, 2, 4 -> weight_sum 3, 4, 5; approved=1 two cycles after signer 4 is sampled.
2. Same cycle: live and pre both signer 3 -> live_ack=1; pre_reject=1 with pre_code=2; weight_sum +1 only.
3. Rejections:
   - live_tag mismatch -> code 3
   - signer 20 -> code 1
   - pre_expiry=100 with current_timestamp=100 -> code 3
   - weight_sum unchanged in every case
4. TIMEOUT_CYCLES=16, threshold 5, only 2 approvals -> denied=1, timeout_flag=1 exactly 16 cycles after entering COLLECT.
5. cfg_k_we during COLLECT ignored. threshold=0 then req_start -> cfg_error=1, denied=1. req_clear -> IDLE with all flags cleared.
6. GOV_VETO_EN: veto from signer 1 in the same cycle weight_sum would reach threshold -> vetoed=1, denied=1, approved=0.
